// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: queue entry layout and FSM states.
// Build option: BRANCH_RESOLVER_STATS_EN adds resolution/mispredict counters.
package branch_resolver_pkg;

    localparam int XLEN_DEF = 32;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic                taken;
        logic [XLEN_DEF-1:0] target;
    } entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/branch_resolver_fifo.sv
// In-order queue of outstanding predictions, oldest entry shown at head_o.
// Clear wins over a same-cycle push so a flush leaves the queue empty.
module branch_resolver_fifo
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  entry_t      data_i,
    input  logic        pop_i,
    input  logic        clear_i,
    output entry_t      head_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] count_o
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == DEPTH_C);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rptr_q];
    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    // Entry storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Matches predictions against execute outcomes, trains the predictor and
// raises a one-cycle flush on mispredict. Option: BRANCH_RESOLVER_STATS_EN.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pred_valid,
    output logic            pred_ready,
    input  logic [XLEN-1:0] pred_pc,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    input  logic            res_valid,
    output logic            res_ready,
    input  logic            res_taken,
    input  logic [XLEN-1:0] res_target,
    output logic            upd_valid,
    input  logic            upd_ready,
    output logic [XLEN-1:0] upd_pc,
    output logic            upd_taken,
    output logic [XLEN-1:0] upd_target,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [15:0]     resolved_cnt,
    output logic [15:0]     mispred_cnt
`endif
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_e          state_q, state_d;
    entry_t          push_e, head_e;
    logic            full, empty;
    logic [AW:0]     count;
    logic            run, push, pop, mispred, clear;
    logic            upd_valid_q;
    logic [XLEN-1:0] upd_pc_q, upd_target_q;
    logic            upd_taken_q;
    logic [XLEN-1:0] redir_q, redir_d;

    assign push_e = '{pc: pred_pc, taken: pred_taken, target: pred_target};

    assign run        = (state_q == RUN);
    assign pred_ready = run && !full && (count < DEPTH_C);
    assign res_ready  = run && !empty && (!upd_valid_q || upd_ready);
    assign push       = pred_valid && pred_ready;
    assign pop        = res_valid && res_ready;
    assign mispred    = (head_e.taken != res_taken)
                     || (head_e.taken && (head_e.target != res_target));
    assign clear      = pop && mispred;

    branch_resolver_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_e),
        .pop_i   (pop),
        .clear_i (clear),
        .head_o  (head_e),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // FSM next state and the redirect address captured on mispredict.
    always_comb begin
        state_d = state_q;
        redir_d = redir_q;
        unique case (state_q)
            RUN: begin
                if (clear) begin
                    state_d = FLUSH;
                    redir_d = res_taken ? res_target
                                        : head_e.pc + XLEN'(4);
                end
            end
            FLUSH: begin
                state_d = RUN;
                redir_d = '0;
            end
            default: begin
                state_d = RUN;
                redir_d = '0;
            end
        endcase
    end

    // FSM state and redirect register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            redir_q <= redir_d;
        end
    end

    // Training write: loaded on acceptance, held until the predictor takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid_q  <= 1'b0;
            upd_pc_q     <= '0;
            upd_taken_q  <= 1'b0;
            upd_target_q <= '0;
        end else if (pop) begin
            upd_valid_q  <= 1'b1;
            upd_pc_q     <= head_e.pc;
            upd_taken_q  <= res_taken;
            upd_target_q <= res_target;
        end else if (upd_ready) begin
            upd_valid_q  <= 1'b0;
        end
    end

    assign upd_valid   = upd_valid_q;
    assign upd_pc      = upd_pc_q;
    assign upd_taken   = upd_taken_q;
    assign upd_target  = upd_target_q;
    assign flush       = (state_q == FLUSH);
    assign redirect_pc = flush ? redir_q : '0;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0] resolved_q, mispred_q;

    // Free-running event counters, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolved_q <= '0;
            mispred_q  <= '0;
        end else begin
            if (pop) begin
                resolved_q <= resolved_q + 16'd1;
            end
            if (clear) begin
                mispred_q <= mispred_q + 16'd1;
            end
        end
    end

    assign resolved_cnt = resolved_q;
    assign mispred_cnt  = mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: queue-based reference model,
// directed scenarios then random traffic with a mid-run reset.
module tb_branch_resolver;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pred_valid = 1'b0;
    logic        pred_ready;
    logic [31:0] pred_pc = '0;
    logic        pred_taken = 1'b0;
    logic [31:0] pred_target = '0;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        upd_valid;
    logic        upd_ready = 1'b0;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush;
    logic [31:0] redirect_pc;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0] resolved_cnt;
    logic [15:0] mispred_cnt;
`endif

    always #5 clk = ~clk;

    branch_resolver #(
        .XLEN  (32),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pred_valid  (pred_valid),
        .pred_ready  (pred_ready),
        .pred_pc     (pred_pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_taken   (res_taken),
        .res_target  (res_target),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .flush       (flush),
        .redirect_pc (redirect_pc)
`ifdef BRANCH_RESOLVER_STATS_EN
        ,
        .resolved_cnt (resolved_cnt),
        .mispred_cnt  (mispred_cnt)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } rec_t;

    rec_t        mq[$];
    rec_t        sb_upd[$];
    logic [31:0] sb_redir[$];
    bit          m_flush;
    bit          m_upd;
    logic [15:0] m_res;
    logic [15:0] m_mis;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb_upd.delete();
        sb_redir.delete();
        m_flush = 0;
        m_upd   = 0;
        m_res   = '0;
        m_mis   = '0;
    endtask

    task automatic check_reset_outputs();
        check("rst_pred_ready", pred_ready, 1);
        check("rst_res_ready", res_ready, 0);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_upd_pc", upd_pc, 0);
        check("rst_upd_taken", upd_taken, 0);
        check("rst_upd_target", upd_target, 0);
        check("rst_flush", flush, 0);
        check("rst_redirect", redirect_pc, 0);
`ifdef BRANCH_RESOLVER_STATS_EN
        check("rst_resolved_cnt", resolved_cnt, 0);
        check("rst_mispred_cnt", mispred_cnt, 0);
`endif
    endtask

    // One clock of stimulus; the model decides what the next edge does.
    task automatic cycle(input bit pv, input logic [31:0] ppc, input bit pt,
                         input logic [31:0] ptg, input bit rv, input bit rt,
                         input logic [31:0] rtg, input bit ur);
        bit   exp_pr, exp_rr, acc, psh, nflush;
        rec_t e;
        @(posedge clk);
        #1;
        pred_valid  = pv;
        pred_pc     = ppc;
        pred_taken  = pt;
        pred_target = ptg;
        res_valid   = rv;
        res_taken   = rt;
        res_target  = rtg;
        upd_ready   = ur;
        #1;
        exp_pr = !m_flush && (mq.size() < DEPTH);
        exp_rr = !m_flush && (mq.size() != 0) && (!m_upd || ur);
        check("pred_ready", pred_ready, exp_pr);
        check("res_ready", res_ready, exp_rr);
        acc    = rv && exp_rr;
        psh    = pv && exp_pr;
        nflush = 0;
        if (m_upd && ur) m_upd = 0;
        if (acc) begin
            e = mq.pop_front();
            sb_upd.push_back('{e.pc, rt, rtg});
            m_upd = 1;
            m_res++;
            if ((e.taken != rt) || (e.taken && rt && e.target != rtg)) begin
                m_mis++;
                sb_redir.push_back(rt ? rtg : e.pc + 32'd4);
                mq.delete();
                psh    = 0;
                nflush = 1;
            end
        end
        if (psh) mq.push_back('{ppc, pt, ptg});
        m_flush = nflush;
    endtask

    task automatic idle(input int n, input bit ur);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, ur);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        upd_ready  = 1'b0;
        model_reset();
        #2;
        check_reset_outputs();
        @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
    endtask

    bit          stall_prev = 0;
    logic [31:0] hold_pc, hold_target;
    logic        hold_taken;

    // Monitor: consumes expected updates/redirects as the DUT presents them.
    always @(negedge clk) begin
        rec_t        u;
        logic [31:0] r;
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("upd_hold_valid", upd_valid, 1);
                check("upd_hold_pc", upd_pc, hold_pc);
                check("upd_hold_taken", upd_taken, hold_taken);
                check("upd_hold_target", upd_target, hold_target);
            end
            if (upd_valid && upd_ready) begin
                if (sb_upd.size() == 0) begin
                    check("upd_unexpected", upd_pc, 32'hxxxx_xxxx);
                end else begin
                    u = sb_upd.pop_front();
                    check("upd_pc", upd_pc, u.pc);
                    check("upd_taken", upd_taken, u.taken);
                    check("upd_target", upd_target, u.target);
                end
            end
            stall_prev  = upd_valid && !upd_ready;
            hold_pc     = upd_pc;
            hold_taken  = upd_taken;
            hold_target = upd_target;
            if (flush) begin
                if (sb_redir.size() == 0) begin
                    check("flush_unexpected", redirect_pc, 32'hxxxx_xxxx);
                end else begin
                    r = sb_redir.pop_front();
                    check("redirect_pc", redirect_pc, r);
                end
            end else begin
                check("redirect_idle", redirect_pc, 0);
            end
        end
    end

    logic [31:0] tgts [4] = '{32'd2048, 32'd3000, 32'd4096, 32'd8};

    initial begin
        model_reset();
        #3;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Correct taken prediction: update only, no flush.
        cycle(1, 1024, 1, 2048, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 1, 2048, 1);
        idle(2, 1);

        // Direction mispredict.
        cycle(1, 1025, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 1, 4096, 1);
        idle(3, 1);

        // Target mispredict with three younger entries plus a same-cycle push.
        cycle(1, 1024, 1, 2048, 0, 0, 0, 1);
        for (int i = 1; i < 4; i++) cycle(1, 1024 + 4 * i, 0, 0, 0, 0, 0, 1);
        cycle(1, 2000, 0, 0, 1, 1, 3000, 1);
        idle(3, 1);

        // Full queue and update backpressure.
        for (int i = 0; i < 5; i++) cycle(1, 500 + 4 * i, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0, 0, 1);
        idle(2, 1);

        // Not-taken redirect, then pc+4 wrapping past the top of memory.
        cycle(1, 1024, 1, 2048, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 0, 0, 1);
        idle(2, 1);
        cycle(1, 32'hFFFF_FFFC, 1, 2048, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 0, 0, 1);
        idle(2, 1);

        // Reset mid-queue with an update still pending.
        cycle(1, 64, 0, 0, 0, 0, 0, 0);
        cycle(1, 68, 0, 0, 0, 0, 0, 0);
        cycle(1, 72, 0, 0, 1, 0, 0, 0);
        do_reset();
        idle(2, 1);

        // Random traffic with one reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            cycle($urandom_range(0, 1),
                  ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom,
                  $urandom_range(0, 1), tgts[$urandom_range(0, 1)],
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  tgts[$urandom_range(0, 1)],
                  $urandom_range(0, 3) != 0);
        end
        idle(8, 1);

        check("sb_upd_drained", sb_upd.size(), 0);
        check("sb_redir_drained", sb_redir.size(), 0);
`ifdef BRANCH_RESOLVER_STATS_EN
        check("resolved_cnt", resolved_cnt, m_res);
        check("mispred_cnt", mispred_cnt, m_mis);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
